// File: rtl/ariane_pkg.sv
// Shared dcache port types and geometry used by the load/store request masters.
package ariane_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/dcache_req_master.sv
// Single-command dcache port master: index phase, one-cycle tag phase, load data
// return, with a sticky kill that is turned into kill_req at the tag phase.
module dcache_req_master
  import ariane_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [7:0]            req_be_i,
  input  logic [63:0]           req_wdata_i,
  input  logic [1:0]            req_size_i,
  input  logic                  kill_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [63:0]           rsp_rdata_o,
  output dcache_req_i_t         dcache_req_o,
  input  dcache_req_o_t         dcache_rsp_i,
  output logic                  busy_o
);

  localparam int unsigned PADDR_W = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    SEND_TAG,
    WAIT_RVALID,
    RSP
  } state_e;

  state_e             state_q, state_d;
  logic               kill_q, kill_d;
  logic [PADDR_W-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [7:0]         be_q, be_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic [63:0]        rdata_q, rdata_d;

  logic req_ready_q, busy_q, data_req_q, tag_valid_q, kill_req_q, rsp_valid_q;

  // Address bits above the cache geometry never reach the port.
  if (ADDR_WIDTH > PADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[ADDR_WIDTH-1:PADDR_W];
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = PADDR_W'(req_addr_i);
          we_d    = req_we_i;
          be_d    = req_be_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        kill_d = kill_q | kill_i;
        if (dcache_rsp_i.data_gnt) state_d = SEND_TAG;
      end
      SEND_TAG: begin
        kill_d  = kill_q | kill_i;
        state_d = (we_q || kill_q) ? IDLE : WAIT_RVALID;
      end
      WAIT_RVALID: begin
        kill_d = kill_q | kill_i;
        if (dcache_rsp_i.data_rvalid) begin
          if (kill_d) begin
            state_d = IDLE;
          end else begin
            rdata_d = dcache_rsp_i.data_rdata;
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) kill_d = 1'b0;
  end

  // Outputs are decoded from the next state so they are registered with it;
  // the tag-phase flavour uses the kill flag that will be held in SEND_TAG.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      data_req_q  <= 1'b0;
      tag_valid_q <= 1'b0;
      kill_req_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      rdata_q     <= rdata_d;
      req_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      data_req_q  <= (state_d == WAIT_GNT);
      tag_valid_q <= (state_d == SEND_TAG) && !kill_d;
      kill_req_q  <= (state_d == SEND_TAG) && kill_d;
      rsp_valid_q <= (state_d == RSP);
    end
  end

  always_comb begin
    dcache_req_o               = '0;
    dcache_req_o.address_index = addr_q[DCACHE_INDEX_WIDTH-1:0];
    dcache_req_o.address_tag   = addr_q[PADDR_W-1:DCACHE_INDEX_WIDTH];
    dcache_req_o.data_wdata    = wdata_q;
    dcache_req_o.data_req      = data_req_q;
    dcache_req_o.data_we       = we_q;
    dcache_req_o.data_be       = be_q;
    dcache_req_o.data_size     = size_q;
    dcache_req_o.kill_req      = kill_req_q;
    dcache_req_o.tag_valid     = tag_valid_q;
  end

  assign req_ready_o = req_ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;

endmodule
